// File: rtl/sb_rx_pkg.sv
// Shared defaults for the sideband receive path.
package sb_rx_pkg;
    localparam int SB_WORD_W        = 64;
    localparam int SB_GAP_UI        = 32;
    localparam int SB_RX_FIFO_DEPTH = 4;
endpackage

// File: rtl/sb_rx_deser_param_if.sv
// Parallel word handshake between the deserializer and the packet decoder.
interface sb_rx_deser_param_if
    import sb_rx_pkg::*;
#(
    parameter int WORD_W = SB_WORD_W
);
    // Valid/ready: a word transfers on every edge where par_vld & par_rdy are both high;
    // par_data holds steady while par_vld is high and no transfer occurs.
    logic [WORD_W-1:0] par_data;
    logic              par_vld;
    logic              par_rdy;

    modport master (output par_data, output par_vld, input par_rdy);
    modport slave  (input par_data, input par_vld, output par_rdy);
endinterface

// File: rtl/sb_rx_fifo.sv
// Show-ahead FIFO: the head word is always visible on o_rdata; pointers carry one wrap bit.
module sb_rx_fifo
    import sb_rx_pkg::*;
#(
    parameter int WIDTH = SB_WORD_W,
    parameter int DEPTH = SB_RX_FIFO_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [LW-1:0]    o_level
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push;
    logic             do_pop;
    logic [AW:0]      used;

    assign o_empty = (wr_q == rd_q);
    assign o_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign used    = wr_q - rd_q;
    assign o_level = LW'(used);
    assign o_rdata = mem_q[rd_q[AW-1:0]];

    always_comb begin
        do_pop  = i_pop & ~o_empty;
        // A push into a full FIFO is accepted only when the head leaves on the same edge.
        do_push = i_push & (~o_full | do_pop);
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (do_push) begin
            mem_d[wr_q[AW-1:0]] = i_wdata;
            wr_d                = wr_q + {{AW{1'b0}}, 1'b1};
        end
        if (do_pop) begin
            rd_d = rd_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
        end
    end
endmodule

// File: rtl/sb_rx_deser_param.sv
// Sideband RX deserializer: serial bits -> WORD_W words with bit-order select, gap-based
// fragment discard and overflow reporting, buffered in a show-ahead FIFO.
module sb_rx_deser_param
    import sb_rx_pkg::*;
#(
    parameter int WORD_W      = SB_WORD_W,
    parameter int FIFO_DEPTH  = SB_RX_FIFO_DEPTH,
    parameter int MSB_FIRST   = 1,
    parameter int GAP_TIMEOUT = SB_GAP_UI,
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic                  i_ser_vld,
    input  logic                  i_ser_data,
    sb_rx_deser_param_if.master   par,
    output logic [LVL_W-1:0]      o_fifo_level,
    output logic                  o_overflow,
    output logic                  o_frag_err
);
    localparam int CNT_W  = $clog2(WORD_W);
    localparam int IDLE_W = $clog2(GAP_TIMEOUT + 1);

    logic [WORD_W-1:0] sr_q, sr_d, sr_next;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              ovf_q, ovf_d;
    logic              frag_q, frag_d;
    logic              acc;
    logic              word_done;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W-1:0] fifo_rdata;

    assign pop          = par.par_vld & par.par_rdy;
    assign par.par_vld  = ~fifo_empty;
    assign par.par_data = fifo_rdata;
    assign o_overflow   = ovf_q;
    assign o_frag_err   = frag_q;

    always_comb begin
        acc       = i_enable & i_ser_vld;
        word_done = acc && (bit_cnt_q == CNT_W'(WORD_W - 1));
        if (MSB_FIRST != 0) begin
            sr_next = {sr_q[WORD_W-2:0], i_ser_data};
        end else begin
            sr_next = {i_ser_data, sr_q[WORD_W-1:1]};
        end
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        idle_d    = idle_q;
        frag_d    = 1'b0;
        ovf_d     = word_done & fifo_full & ~pop;
        if (!i_enable) begin
            sr_d      = '0;
            bit_cnt_d = '0;
            idle_d    = '0;
        end else if (acc) begin
            sr_d      = sr_next;
            idle_d    = '0;
            bit_cnt_d = word_done ? '0 : bit_cnt_q + CNT_W'(1);
        end else if (bit_cnt_q != '0) begin
            // This idle cycle is the GAP_TIMEOUT-th in a row: drop the partial word.
            if (idle_q == IDLE_W'(GAP_TIMEOUT - 1)) begin
                sr_d      = '0;
                bit_cnt_d = '0;
                idle_d    = '0;
                frag_d    = 1'b1;
            end else begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
            idle_q    <= '0;
            ovf_q     <= 1'b0;
            frag_q    <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            idle_q    <= idle_d;
            ovf_q     <= ovf_d;
            frag_q    <= frag_d;
        end
    end

    sb_rx_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (word_done),
        .i_wdata (sr_next),
        .i_pop   (pop),
        .o_rdata (fifo_rdata),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_level (o_fifo_level)
    );
endmodule

// File: tb/tb_sb_rx_deser_param.sv
// Bench for sb_rx_deser_param: 64-bit MSB-first instance checked every cycle against a
// queue-based model, two 8-bit instances for bit-order checks, plus directed literals.
module tb_sb_rx_deser_param;
    localparam int W     = 64;
    localparam int DEPTH = 4;
    localparam int GAP   = 32;
    localparam int MSB64 = 1;

    logic clk      = 1'b0;
    logic rst_n    = 1'b1;
    logic en64     = 1'b0;
    logic en8      = 1'b0;
    logic ser_vld  = 1'b0;
    logic ser_data = 1'b0;
    logic rdy      = 1'b0;
    logic rdy8     = 1'b1;
    logic chk_en   = 1'b0;

    logic [2:0] lvl64, lvl8l, lvl8m;
    logic       ovf64, frag64, ovf8l, frag8l, ovf8m, frag8m;

    int tests_run    = 0;
    int tests_failed = 0;
    int frag_seen    = 0;
    int ovf_seen     = 0;

    sb_rx_deser_param_if #(.WORD_W(64)) p64 ();
    sb_rx_deser_param_if #(.WORD_W(8))  p8l ();
    sb_rx_deser_param_if #(.WORD_W(8))  p8m ();

    assign p64.par_rdy = rdy;
    assign p8l.par_rdy = rdy8;
    assign p8m.par_rdy = rdy8;

    always #5 clk = ~clk;

    sb_rx_deser_param #(.WORD_W(64), .FIFO_DEPTH(4), .MSB_FIRST(1), .GAP_TIMEOUT(32)) dut64 (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en64), .i_ser_vld(ser_vld),
        .i_ser_data(ser_data), .par(p64), .o_fifo_level(lvl64),
        .o_overflow(ovf64), .o_frag_err(frag64)
    );
    sb_rx_deser_param #(.WORD_W(8), .FIFO_DEPTH(4), .MSB_FIRST(0), .GAP_TIMEOUT(32)) dut8l (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en8), .i_ser_vld(ser_vld),
        .i_ser_data(ser_data), .par(p8l), .o_fifo_level(lvl8l),
        .o_overflow(ovf8l), .o_frag_err(frag8l)
    );
    sb_rx_deser_param #(.WORD_W(8), .FIFO_DEPTH(4), .MSB_FIRST(1), .GAP_TIMEOUT(32)) dut8m (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en8), .i_ser_vld(ser_vld),
        .i_ser_data(ser_data), .par(p8m), .o_fifo_level(lvl8m),
        .o_overflow(ovf8m), .o_frag_err(frag8m)
    );

    // Model of the 64-bit instance: bits of the current fragment, stored words, pulses.
    bit         fb[$];
    logic [W-1:0] fq[$];
    int         idle_m;
    logic       exp_ovf;
    logic       exp_frag;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests_run++;
        if (act !== expv) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [W-1:0] assemble();
        logic [W-1:0] word = '0;
        for (int i = 0; i < W; i++) begin
            if (MSB64 != 0) word[W-1-i] = fb[i];
            else            word[i]     = fb[i];
        end
        return word;
    endfunction

    task automatic model_reset();
        fb.delete();
        fq.delete();
        idle_m   = 0;
        exp_ovf  = 1'b0;
        exp_frag = 1'b0;
    endtask

    task automatic model_step();
        logic         pop;
        logic         push;
        logic [W-1:0] word;
        pop      = (fq.size() != 0) && rdy;
        push     = 1'b0;
        word     = '0;
        exp_ovf  = 1'b0;
        exp_frag = 1'b0;
        if (!en64) begin
            fb.delete();
            idle_m = 0;
        end else if (ser_vld) begin
            fb.push_back(ser_data);
            idle_m = 0;
            if (fb.size() == W) begin
                word = assemble();
                fb.delete();
                push = 1'b1;
            end
        end else if (fb.size() != 0) begin
            idle_m++;
            if (idle_m == GAP) begin
                fb.delete();
                idle_m   = 0;
                exp_frag = 1'b1;
            end
        end
        if (pop) void'(fq.pop_front());
        if (push) begin
            if (fq.size() < DEPTH) fq.push_back(word);
            else                   exp_ovf = 1'b1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && chk_en) begin
                check("vld", 64'(p64.par_vld), 64'(fq.size() != 0));
                if (fq.size() != 0) check("data", p64.par_data, fq[0]);
                check("level", 64'(lvl64), 64'(fq.size()));
                check("overflow", 64'(ovf64), 64'(exp_ovf));
                check("frag_err", 64'(frag64), 64'(exp_frag));
                if (frag64) frag_seen++;
                if (ovf64)  ovf_seen++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends the low n bits of w, most significant of those first.
    task automatic send_word(input logic [63:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            ser_vld  = 1'b1;
            ser_data = w[n-1-i];
            @(posedge clk);
            #1;
        end
        ser_vld  = 1'b0;
        ser_data = 1'b0;
    endtask

    logic [63:0] words [5];
    logic [63:0] x_word;
    logic [63:0] y_word;
    logic [63:0] z_word;
    int          frag_base;
    int          ovf_base;

    initial begin
        words[0] = 64'h1111_0000_0000_0001;
        words[1] = 64'h2222_0000_0000_0002;
        words[2] = 64'h3333_0000_0000_0003;
        words[3] = 64'h4444_0000_0000_0004;
        words[4] = 64'h5555_0000_0000_0005;
        x_word   = 64'h0123_4567_89AB_CDEF;
        y_word   = 64'hFEDC_BA98_7654_3210;
        z_word   = 64'hC0DE_CAFE_F00D_BEEF;

        #2 rst_n = 1'b0;
        tick(3);
        check("rst_data", p64.par_data, 64'h0);
        check("rst_vld", 64'(p64.par_vld), 64'h0);
        check("rst_level", 64'(lvl64), 64'h0);
        check("rst_ovf", 64'(ovf64), 64'h0);
        check("rst_frag", 64'(frag64), 64'h0);
        check("rst_vld8", 64'(p8l.par_vld | p8m.par_vld), 64'h0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        en64   = 1'b1;
        rdy    = 1'b1;
        tick(2);

        // One full word, consumer ready: visible for exactly one cycle.
        send_word(64'hA5A5_0000_FFFF_1234, 64);
        check("w64_vld", 64'(p64.par_vld), 64'h1);
        check("w64_data", p64.par_data, 64'hA5A5_0000_FFFF_1234);
        tick(1);
        check("w64_drained", 64'(p64.par_vld), 64'h0);
        check("w64_level0", 64'(lvl64), 64'h0);

        // Bit order on the 8-bit instances: bits 1,0,0,0,0,0,0,0.
        en64 = 1'b0;
        en8  = 1'b1;
        tick(1);
        send_word(64'h80, 8);
        check("lsb_first_vld", 64'(p8l.par_vld), 64'h1);
        check("lsb_first_data", 64'(p8l.par_data), 64'h01);
        check("msb_first_data", 64'(p8m.par_data), 64'h80);
        check("lvl8", 64'(lvl8m), 64'h1);
        tick(1);
        check("w8_drained", 64'(p8l.par_vld | p8m.par_vld), 64'h0);
        en8  = 1'b0;
        en64 = 1'b1;
        tick(1);

        // Five words into a stalled depth-4 FIFO.
        rdy      = 1'b0;
        ovf_base = ovf_seen;
        for (int i = 0; i < 5; i++) send_word(words[i], 64);
        check("ovf_pulse", 64'(ovf64), 64'h1);
        check("full_level", 64'(lvl64), 64'h4);
        tick(1);
        check("ovf_one_cycle", 64'(ovf64), 64'h0);
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_order", p64.par_data, words[i]);
            tick(1);
        end
        check("drain_empty", 64'(p64.par_vld), 64'h0);
        check("ovf_count", 64'(ovf_seen - ovf_base), 64'h1);

        // 20 bits then a 32-cycle gap: one fragment error, then a clean word.
        frag_base = frag_seen;
        send_word(64'hABCDE, 20);
        tick(31);
        check("frag_not_yet", 64'(frag64), 64'h0);
        tick(1);
        check("frag_pulse", 64'(frag64), 64'h1);
        tick(1);
        check("frag_one_cycle", 64'(frag64), 64'h0);
        send_word(x_word, 64);
        check("after_frag_data", p64.par_data, x_word);
        check("frag_count", 64'(frag_seen - frag_base), 64'h1);
        tick(1);

        // 31-cycle gap is tolerated.
        frag_base = frag_seen;
        send_word(y_word >> 44, 20);
        tick(31);
        send_word(y_word, 44);
        check("gap31_vld", 64'(p64.par_vld), 64'h1);
        check("gap31_data", p64.par_data, y_word);
        tick(1);

        // Enable dropped for one cycle mid-word: fragment vanishes silently.
        send_word(y_word >> 44, 20);
        en64 = 1'b0;
        tick(1);
        en64 = 1'b1;
        send_word(y_word, 44);
        tick(1);
        check("en_drop_no_word", 64'(lvl64), 64'h0);
        check("no_frag_err", 64'(frag_seen - frag_base), 64'h0);
        en64 = 1'b0;
        tick(1);
        en64 = 1'b1;

        // Full FIFO with a pop on the completing edge: no overflow.
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) send_word(words[i], 64);
        check("refill_level", 64'(lvl64), 64'h4);
        send_word(z_word >> 1, 63);
        rdy = 1'b1;
        send_word(z_word, 1);
        rdy = 1'b0;
        check("pop_push_no_ovf", 64'(ovf64), 64'h0);
        check("pop_push_level", 64'(lvl64), 64'h4);
        check("pop_push_head", p64.par_data, words[1]);

        // Asynchronous reset mid-word with a full FIFO.
        send_word(z_word, 10);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_vld", 64'(p64.par_vld), 64'h0);
        check("async_rst_data", p64.par_data, 64'h0);
        check("async_rst_level", 64'(lvl64), 64'h0);
        check("async_rst_pulses", 64'({ovf64, frag64}), 64'h0);
        tick(2);
        rst_n = 1'b1;
        tick(3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
